// File: rtl/gray_counter_param_pkg.sv
// Shared definitions for the parametrised Gray counter: direction and boundary-mode
// constants, the next-state operation type and Gray/binary helper functions.
package gray_counter_param_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MODE_WRAP = 1;
  localparam int MODE_SAT  = 0;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_STEP = 2'd2
  } step_op_e;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_param_to_bin.sv
// Combinational Gray-to-binary converter built as an XOR prefix from the MSB down.
module gray_to_bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_prefix
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_counter_param.sv
// Parametrised up/down Gray counter with synchronous load, wrap or saturate at the
// boundaries, a registered binary shadow and a one-cycle terminal-count flag.
module gray_counter_param
  import gray_counter_param_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int WRAP  = 1
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] salida_gray,
  output logic [WIDTH-1:0] salida_bin,
  output logic             tc
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("gray_counter_param: WIDTH must be in 2..32");
  end
  if (WRAP != MODE_WRAP && WRAP != MODE_SAT) begin : g_bad_mode
    $error("gray_counter_param: WRAP must be 0 or 1");
  end

  localparam logic [WIDTH-1:0] MAX_COUNT = '1;

  step_op_e         op;
  logic             at_boundary;
  logic             step_blocked;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;
  logic             tc_next;
  logic [WIDTH-1:0] bin_check;

  always_comb begin
    op = OP_HOLD;
    if (load) begin
      op = OP_LOAD;
    end else if (enable) begin
      op = OP_STEP;
    end
  end

  // The boundary depends on the direction requested on this very edge.
  always_comb begin
    at_boundary  = (up_down == DIR_UP) ? (salida_bin == MAX_COUNT)
                                       : (salida_bin == '0);
    step_blocked = at_boundary && (WRAP != MODE_WRAP);
  end

  always_comb begin
    bin_next = salida_bin;
    tc_next  = 1'b0;
    case (op)
      OP_LOAD: begin
        bin_next = load_value;
      end
      OP_STEP: begin
        tc_next = at_boundary;
        if (!step_blocked) begin
          if (up_down == DIR_UP) begin
            bin_next = salida_bin + 1'b1;
          end else begin
            bin_next = salida_bin - 1'b1;
          end
        end
      end
      default: begin
        bin_next = salida_bin;
      end
    endcase
  end

  // Gray comes from the next binary value so both outputs are plain registers.
  assign gray_next = WIDTH'(bin2gray(32'(bin_next)));

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      salida_bin  <= '0;
      salida_gray <= '0;
      tc          <= 1'b0;
    end else begin
      salida_bin  <= bin_next;
      salida_gray <= gray_next;
      tc          <= tc_next;
    end
  end

  gray_to_bin #(.WIDTH(WIDTH)) u_self_check (
    .gray (salida_gray),
    .bin  (bin_check)
  );

  a_shadow_consistent: assert property (@(posedge clk) disable iff (!reset_L)
                                        bin_check == salida_bin);

endmodule

// File: tb/tb_gray_counter_param.sv
// Scoreboard bench for gray_counter_param: directed vectors push expectations, a
// negedge monitor pops and compares them against three counter configurations.
module tb_gray_counter_param;

  typedef struct packed {
    logic [7:0]  bin;
    logic        tc;
    logic        chk_step;
    logic [15:0] tag;
  } exp_t;

  logic clk;

  logic       rst5w, en5w, ud5w, ld5w;
  logic [4:0] lv5w, g5w, b5w, c5w;
  logic       tc5w;

  logic       rst5s, en5s, ud5s, ld5s;
  logic [4:0] lv5s, g5s, b5s, c5s;
  logic       tc5s;

  logic       rst8w, en8w, ud8w, ld8w;
  logic [7:0] lv8w, g8w, b8w, c8w;
  logic       tc8w;

  exp_t q5w[$];
  exp_t q5s[$];
  exp_t q8w[$];
  logic [7:0] prev_g [3];

  int checks = 0;
  int errors = 0;

  gray_counter_param #(.WIDTH(5), .WRAP(1)) dut5w (
    .clk(clk), .reset_L(rst5w), .enable(en5w), .up_down(ud5w), .load(ld5w),
    .load_value(lv5w), .salida_gray(g5w), .salida_bin(b5w), .tc(tc5w)
  );

  gray_counter_param #(.WIDTH(5), .WRAP(0)) dut5s (
    .clk(clk), .reset_L(rst5s), .enable(en5s), .up_down(ud5s), .load(ld5s),
    .load_value(lv5s), .salida_gray(g5s), .salida_bin(b5s), .tc(tc5s)
  );

  gray_counter_param #(.WIDTH(8), .WRAP(1)) dut8w (
    .clk(clk), .reset_L(rst8w), .enable(en8w), .up_down(ud8w), .load(ld8w),
    .load_value(lv8w), .salida_gray(g8w), .salida_bin(b8w), .tc(tc8w)
  );

  gray_to_bin #(.WIDTH(5)) conv5w (.gray(g5w), .bin(c5w));
  gray_to_bin #(.WIDTH(5)) conv5s (.gray(g5s), .bin(c5s));
  gray_to_bin #(.WIDTH(8)) conv8w (.gray(g8w), .bin(c8w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input int dut, input exp_t e, input logic [7:0] g,
                             input logic [7:0] b, input logic [7:0] conv, input logic t);
    logic [7:0] eg;
    eg = e.bin ^ (e.bin >> 1);
    checks++;
    if (b !== e.bin) begin
      errors++;
      $display("[TB] FAIL bin dut%0d tag%0d: got %0d want %0d", dut, e.tag, b, e.bin);
    end
    checks++;
    if (g !== eg) begin
      errors++;
      $display("[TB] FAIL gray dut%0d tag%0d: got %b want %b", dut, e.tag, g, eg);
    end
    checks++;
    if (t !== e.tc) begin
      errors++;
      $display("[TB] FAIL tc dut%0d tag%0d: got %b want %b", dut, e.tag, t, e.tc);
    end
    checks++;
    if (conv !== b) begin
      errors++;
      $display("[TB] FAIL shadow dut%0d tag%0d: gray2bin %0d bin %0d", dut, e.tag, conv, b);
    end
    if (e.chk_step) begin
      checks++;
      if ($countones(g ^ prev_g[dut]) != 1) begin
        errors++;
        $display("[TB] FAIL onebit dut%0d tag%0d: gray %b after %b", dut, e.tag, g, prev_g[dut]);
      end
    end
    prev_g[dut] = g;
  endtask

  always @(negedge clk) begin
    if (q5w.size() != 0) checkOutput(0, q5w.pop_front(), {3'b0, g5w}, {3'b0, b5w}, {3'b0, c5w}, tc5w);
    if (q5s.size() != 0) checkOutput(1, q5s.pop_front(), {3'b0, g5s}, {3'b0, b5s}, {3'b0, c5s}, tc5s);
    if (q8w.size() != 0) checkOutput(2, q8w.pop_front(), g8w, b8w, c8w, tc8w);
  end

  // Drives one DUT for one edge (others idle) and queues what it must show afterwards.
  task automatic applyStimulus(input int dut, input logic rst, input logic en, input logic ud,
                               input logic ld, input logic [7:0] lv, input logic [7:0] exp_bin,
                               input logic exp_tc, input logic chk, input int tag);
    exp_t e;
    @(negedge clk);
    rst5w = 1'b1; en5w = 1'b0; ld5w = 1'b0;
    rst5s = 1'b1; en5s = 1'b0; ld5s = 1'b0;
    rst8w = 1'b1; en8w = 1'b0; ld8w = 1'b0;
    case (dut)
      0: begin rst5w = rst; en5w = en; ud5w = ud; ld5w = ld; lv5w = lv[4:0]; end
      1: begin rst5s = rst; en5s = en; ud5s = ud; ld5s = ld; lv5s = lv[4:0]; end
      default: begin rst8w = rst; en8w = en; ud8w = ud; ld8w = ld; lv8w = lv; end
    endcase
    @(posedge clk);
    #1;
    e.bin = exp_bin;
    e.tc = exp_tc;
    e.chk_step = chk;
    e.tag = 16'(tag);
    case (dut)
      0: q5w.push_back(e);
      1: q5s.push_back(e);
      default: q8w.push_back(e);
    endcase
  endtask

  initial begin
    logic [7:0] mb, lv, eb;
    logic rst, en, ud, ld, t, chk, dir;

    rst5w = 1'b0; en5w = 1'b0; ud5w = 1'b1; ld5w = 1'b0; lv5w = '0;
    rst5s = 1'b0; en5s = 1'b0; ud5s = 1'b1; ld5s = 1'b0; lv5s = '0;
    rst8w = 1'b0; en8w = 1'b0; ud8w = 1'b1; ld8w = 1'b0; lv8w = '0;
    for (int i = 0; i < 3; i++) prev_g[i] = '0;

    // Full up sweep with wrap; tc only on the 31 -> 0 step.
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 100);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 100);
    for (int i = 1; i <= 32; i++) begin
      applyStimulus(0, 1, 1, 1, 0, 0, 8'(i % 32), (i == 32), 1, 100 + i);
    end

    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 200);
    applyStimulus(0, 1, 1, 0, 0, 0, 31, 1, 1, 201);
    applyStimulus(0, 1, 1, 0, 0, 0, 30, 0, 1, 202);
    applyStimulus(0, 1, 0, 1, 0, 0, 30, 0, 0, 203);

    // Saturating instance at both ends.
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0, 300);
    applyStimulus(1, 1, 0, 1, 1, 30, 30, 0, 0, 301);
    applyStimulus(1, 1, 1, 1, 0, 0, 31, 0, 1, 302);
    applyStimulus(1, 1, 1, 1, 0, 0, 31, 1, 0, 303);
    applyStimulus(1, 1, 1, 1, 0, 0, 31, 1, 0, 304);
    applyStimulus(1, 1, 1, 0, 0, 0, 30, 0, 1, 305);
    applyStimulus(1, 1, 0, 0, 1, 0, 0, 0, 0, 306);
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 1, 0, 307);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 308);

    applyStimulus(0, 1, 1, 1, 1, 13, 13, 0, 0, 400);
    applyStimulus(0, 0, 1, 1, 1, 20, 0, 0, 0, 401);

    for (int i = 1; i <= 9; i++) begin
      applyStimulus(0, 1, 1, 1, 0, 0, 8'(i), 0, 1, 500 + i);
    end
    applyStimulus(0, 0, 1, 1, 0, 0, 0, 0, 0, 510);
    applyStimulus(0, 1, 1, 1, 0, 0, 1, 0, 1, 511);

    // Random traffic on the 8-bit instance against a behavioural model.
    mb = '0;
    dir = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 63) == 0) dir = ~dir;
      rst = (i < 2) ? 1'b0 : ($urandom_range(0, 99) != 0);
      ld  = ($urandom_range(0, 15) == 0);
      en  = ($urandom_range(0, 3) != 0);
      ud  = dir ^ ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 4))
        0: lv = 8'h00;
        1: lv = 8'hFF;
        2: lv = 8'hFE;
        3: lv = 8'h01;
        default: lv = 8'($urandom_range(0, 255));
      endcase
      if (!rst) begin
        mb = '0; t = 1'b0; chk = 1'b0;
      end else if (ld) begin
        mb = lv; t = 1'b0; chk = 1'b0;
      end else if (en) begin
        t = ud ? (mb == 8'hFF) : (mb == 8'h00);
        mb = ud ? mb + 8'd1 : mb - 8'd1;
        chk = 1'b1;
      end else begin
        t = 1'b0; chk = 1'b0;
      end
      eb = mb;
      applyStimulus(2, rst, en, ud, ld, lv, eb, t, chk, 1000 + (i % 60000));
    end

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ((q5w.size() + q5s.size() + q8w.size()) != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, want 0",
               q5w.size() + q5s.size() + q8w.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
